// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types and constants for the sub-word store read-modify-write controller.
package store_rmw_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic int word_addr_w(input int addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_merge.sv
// Byte-lane merge of store data into an old memory word, handled per 16-bit half.
module write_data_mask_32 (
  input  logic [3:0]  mask_i,
  input  logic [15:0] wdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] data_o
);

  // Sub-word data always comes from the low bits, so both halves see wdata_i.
  function automatic logic [15:0] merge_half(
    input logic [1:0]  m,
    input logic [15:0] w,
    input logic [15:0] o
  );
    logic [15:0] r;
    unique case (m)
      2'b11:   r = w;
      2'b10:   r = {w[7:0], o[7:0]};
      2'b01:   r = {o[15:8], w[7:0]};
      default: r = o;
    endcase
    return r;
  endfunction

  assign data_o = {
    merge_half(mask_i[3:2], wdata_i, old_i[31:16]),
    merge_half(mask_i[1:0], wdata_i, old_i[15:0])
  };

endmodule

// File: rtl/store_rmw_ctrl.sv
// Owns the data memory port: word loads, full-word stores and sub-word
// stores done as read-modify-write against a word-only memory.
module store_rmw_ctrl
  import store_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [3:0]                     req_mask,
  input  logic [31:0]                    req_wdata,
  output logic                           done,
  output logic [31:0]                    rsp_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [word_addr_w(ADDR_W)-1:0] mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic [31:0]                    mem_rdata,
  input  logic                           mem_ack,
  output logic [CNT_W-1:0]               rmw_cnt
);

  localparam int WA_W = word_addr_w(ADDR_W);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              rmw_q, rmw_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [WA_W-1:0]   addr_q, addr_d;
  logic              en_q, en_d;
  logic              mwe_q, mwe_d;
  logic [31:0]       mwd_q, mwd_d;
  logic [31:0]       rsp_q, rsp_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       merged;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];

  write_data_mask_32 u_merge (
    .mask_i  (mask_q),
    .wdata_i (wdata_q),
    .old_i   (mem_rdata),
    .data_o  (merged)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    rmw_d   = rmw_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    en_d    = en_q;
    mwe_d   = mwe_q;
    mwd_d   = mwd_q;
    rsp_d   = rsp_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && rdy_q) begin
          we_d    = req_we;
          mask_d  = req_mask;
          wdata_d = req_wdata[15:0];
          addr_d  = req_addr[ADDR_W-1:2];
          rmw_d   = 1'b0;
          if (!req_we) begin
            state_d = ST_RD;
            en_d    = 1'b1;
          end else if (req_mask == MASK_WORD) begin
            state_d = ST_WR;
            en_d    = 1'b1;
            mwe_d   = 1'b1;
            mwd_d   = req_wdata;
          end else if (req_mask == MASK_NONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
            en_d    = 1'b1;
            rmw_d   = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          if (!we_q) begin
            state_d = ST_DONE;
            rsp_d   = mem_rdata;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WR;
            mwd_d   = merged;
            mwe_d   = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          mwe_d   = 1'b0;
          done_d  = 1'b1;
          if (rmw_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      rmw_q   <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      mwe_q   <= 1'b0;
      mwd_q   <= '0;
      rsp_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      rmw_q   <= rmw_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      mwe_q   <= mwe_d;
      mwd_q   <= mwd_d;
      rsp_q   <= rsp_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = rdy_q;
  assign done      = done_q;
  assign rsp_rdata = rsp_q;
  assign mem_en    = en_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mwd_q;
  assign rmw_cnt   = cnt_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with a wait-state memory model.
module tb_store_rmw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  wire         req_ready, done, mem_en, mem_we;
  wire  [29:0] mem_addr;
  wire  [31:0] mem_wdata, rsp_rdata;
  wire  [15:0] rmw_cnt;

  wire         d2_ready, d2_done, d2_en, d2_we;
  wire  [29:0] d2_addr;
  wire  [31:0] d2_wdata, d2_rsp;
  wire  [1:0]  d2_cnt;

  store_rmw_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .done(done), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rmw_cnt(rmw_cnt)
  );

  store_rmw_ctrl #(.ADDR_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(d2_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .done(d2_done), .rsp_rdata(d2_rsp),
    .mem_en(d2_en), .mem_we(d2_we),
    .mem_addr(d2_addr), .mem_wdata(d2_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rmw_cnt(d2_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] mem [int];
  int          wait_n = 0;
  int          wcnt = 0;
  bit          spurious = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_wd = '0;
  logic [29:0] last_wa = '0;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
    if (rst || !mem_en) begin
      wcnt = 0;
      mem_ack = spurious;
    end else if (wcnt >= wait_n) begin
      mem_ack = 1'b1;
      mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'h0;
    end else begin
      wcnt++;
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_en && mem_we && mem_ack) begin
      mem[int'(mem_addr)] = mem_wdata;
      wr_count++;
      last_wd = mem_wdata;
      last_wa = mem_addr;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] old;
    int          t_done;
    int          n_rd;
    int          n_wr;
    logic [31:0] exp_wd;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        v [8];
  logic [31:0] last_load = 32'h0;

  task automatic run(input vec_t x, input logic [31:0] exp_rsp);
    int k, nrd, wr0, stab;
    logic pen, pwe, saw_en, saw_we;
    logic [29:0] pa;
    logic [31:0] pwd;
    mem[int'(x.addr >> 2)] = x.old;
    wait_n = x.wt;
    wr0 = wr_count;
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_we = x.we;
    req_addr = x.addr;
    req_mask = x.mask;
    req_wdata = x.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1; nrd = 0; stab = 0;
    pen = mem_en; pwe = mem_we; pa = mem_addr; pwd = mem_wdata;
    saw_en = mem_en; saw_we = mem_we;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (pen && mem_ack) begin
        if (!pwe) nrd++;
      end else if (pen) begin
        if (mem_en !== pen || mem_we !== pwe ||
            mem_addr !== pa || mem_wdata !== pwd)
          stab++;
      end
      saw_en |= mem_en;
      saw_we |= mem_we;
      pen = mem_en; pwe = mem_we; pa = mem_addr; pwd = mem_wdata;
    end
    chk("done_cycle", k, x.t_done);
    chk("reads", nrd, x.n_rd);
    chk("writes", wr_count - wr0, x.n_wr);
    chk("mem_en_used", saw_en, (x.n_rd + x.n_wr) > 0);
    chk("wait_stable", stab, 0);
    if (x.n_wr > 0) begin
      chk("write_data", last_wd, x.exp_wd);
      chk("write_addr", last_wa, x.addr[31:2]);
    end
    if (!x.we) chk("load_no_we", saw_we, 0);
    chk("rsp_rdata", rsp_rdata, exp_rsp);
    chk("rmw_cnt", rmw_cnt, x.exp_cnt);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, dones, acc, last_k, wr0;
    logic pr;
    logic [15:0] cnt0;

    v[0] = '{1'b1, 32'h100, 4'b0100, 32'h000000AA, 0, 32'h11223344,
             3, 1, 1, 32'h11AA3344, 16'd1};
    v[1] = '{1'b1, 32'h204, 4'b0011, 32'h00001234, 2, 32'hDEADBEEF,
             7, 1, 1, 32'hDEAD1234, 16'd2};
    v[2] = '{1'b1, 32'h300, 4'b1111, 32'hCAFEF00D, 0, 32'h00000000,
             2, 0, 1, 32'hCAFEF00D, 16'd2};
    v[3] = '{1'b1, 32'h304, 4'b0000, 32'h12345678, 0, 32'h87654321,
             1, 0, 0, 32'h0, 16'd2};
    v[4] = '{1'b0, 32'h400, 4'b1111, 32'h0, 0, 32'h55AA00FF,
             2, 1, 0, 32'h0, 16'd2};
    v[5] = '{1'b1, 32'h500, 4'b0110, 32'h000077BB, 1, 32'hA1B2C3D4,
             5, 1, 1, 32'hA1BBBBD4, 16'd3};
    v[6] = '{1'b1, 32'h601, 4'b1000, 32'h0000005A, 0, 32'h01020304,
             3, 1, 1, 32'h5A020304, 16'd4};
    v[7] = '{1'b0, 32'h700, 4'b0101, 32'h0, 3, 32'h0BADCAFE,
             5, 1, 0, 32'h0, 16'd4};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_mask = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp", rsp_rdata, 0);
    chk("rst_cnt", rmw_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (!v[i].we) last_load = v[i].old;
      run(v[i], last_load);
    end
    chk("sat_cnt", d2_cnt, 3);

    mem[int'(32'h800 >> 2)] = 32'h01020304;
    wait_n = 0;
    cnt0 = rmw_cnt;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h800;
    req_mask = 4'b0001;
    req_wdata = 32'h00000011;
    k = 0; dones = 0; acc = 0; last_k = 0;
    while (dones < 3 && k < 60) begin
      pr = req_ready;
      @(posedge clk); #1;
      k++;
      if (pr) acc++;
      if (done) begin
        dones++;
        last_k = k;
      end
    end
    req_valid = 1'b0;
    chk("b2b_dones", dones, 3);
    chk("b2b_accepts", acc, 3);
    chk("b2b_last_done", last_k, 11);
    chk("b2b_cnt", rmw_cnt, cnt0 + 16'd3);
    chk("b2b_sat_cnt", d2_cnt, 3);
    chk("b2b_word", mem[int'(32'h800 >> 2)], 32'h01020311);
    @(posedge clk); #1;

    mem[int'(32'h900 >> 2)] = 32'h99999999;
    wait_n = 5;
    wr0 = wr_count;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h900;
    req_mask = 4'b0010;
    req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rdwait_en", mem_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", rmw_cnt, 0);
    chk("mid_rst_cnt2", d2_cnt, 0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || mem_en) dones++;
    end
    chk("mid_rst_quiet", dones, 0);
    chk("mid_rst_nowrite", wr_count - wr0, 0);

    spurious = 1'b1;
    @(posedge clk); #1;
    spurious = 1'b0;
    chk("spur_en", mem_en, 0);
    chk("spur_done", done, 0);
    chk("spur_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
